// File: rtl/drum_sector_locator.sv
// Drum timing-track decoder: recovers word framing (Z2) and sector address (Z3),
// then gates a one-word MATCH window for a requested target sector.
module drum_sector_locator (
    input  logic       Z1,
    input  logic       CLR,
    input  logic       Z2,
    input  logic       Z3,
    input  logic       REQ,
    input  logic [6:0] TGT,
    output logic       LOCK,
    output logic [5:0] PH,
    output logic [6:0] SECT,
    output logic       SECT_VALID,
    output logic       INDEX,
    output logic       MATCH,
    output logic       ACK,
    output logic       ERR,
    output logic       SYNC_ERR
);

    typedef enum logic {
        F_HUNT,
        F_LOCKED
    } frame_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_XFER,
        S_DONE,
        S_FAIL
    } srch_t;

    frame_t     r_fstate;
    logic [4:0] r_lowrun;
    logic [5:0] r_ph;
    logic [6:0] r_asm;
    logic [6:0] r_sect;
    logic       r_sect_valid;
    logic       r_index;
    logic       r_sync_err;

    srch_t      r_sstate;
    logic [6:0] r_tgt;
    logic       r_idx_seen;
    logic       r_match;
    logic       r_ack;
    logic       r_err;

    logic       w_locked;
    logic       w_exp_z2;
    logic       w_asm_zero;
    logic       w_frame_err;
    logic       w_field_end;
    logic [5:0] w_ph_next;

    always_comb begin
        w_locked    = (r_fstate == F_LOCKED);
        w_exp_z2    = ((r_ph >= 6'd31) && (r_ph <= 6'd33)) || (r_ph >= 6'd38);
        w_asm_zero  = (r_asm == '0);
        // The index flag at bit 39 must agree with the address just assembled.
        w_frame_err = w_locked &&
                      ((Z2 != w_exp_z2) || ((r_ph == 6'd39) && (Z3 != w_asm_zero)));
        w_field_end = w_locked && (r_ph == 6'd39) && !w_frame_err;
        w_ph_next   = (r_ph == 6'd39) ? '0 : r_ph + 6'd1;
    end

    always_ff @(posedge Z1 or negedge CLR) begin
        if (!CLR) begin
            r_fstate     <= F_HUNT;
            r_lowrun     <= '0;
            r_ph         <= '0;
            r_asm        <= '0;
            r_sect       <= '0;
            r_sect_valid <= 1'b0;
            r_index      <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_index    <= 1'b0;
            r_sync_err <= 1'b0;
            case (r_fstate)
                F_HUNT: begin
                    if (!Z2) begin
                        if (r_lowrun != 5'd31) begin
                            r_lowrun <= r_lowrun + 5'd1;
                        end
                    end else if (r_lowrun == 5'd31) begin
                        // 31 zeros followed by a one can only be bit 31 of a word.
                        r_ph     <= 6'd32;
                        r_fstate <= F_LOCKED;
                    end else begin
                        r_lowrun <= '0;
                    end
                end
                F_LOCKED: begin
                    if (w_frame_err) begin
                        r_sync_err   <= 1'b1;
                        r_fstate     <= F_HUNT;
                        r_lowrun     <= '0;
                        r_sect_valid <= 1'b0;
                        r_ph         <= '0;
                    end else begin
                        r_ph <= w_ph_next;
                        if ((r_ph >= 6'd32) && (r_ph <= 6'd38)) begin
                            r_asm <= {Z3, r_asm[6:1]};
                        end
                        if (r_ph == 6'd39) begin
                            r_sect       <= r_asm;
                            r_sect_valid <= 1'b1;
                            r_index      <= w_asm_zero;
                        end
                    end
                end
                default: begin
                    r_fstate <= F_HUNT;
                    r_lowrun <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge Z1 or negedge CLR) begin
        if (!CLR) begin
            r_sstate   <= S_IDLE;
            r_tgt      <= '0;
            r_idx_seen <= 1'b0;
            r_match    <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_sstate)
                S_IDLE: begin
                    r_idx_seen <= 1'b0;
                    if (REQ) begin
                        r_tgt    <= TGT;
                        r_sstate <= S_SEEK;
                    end
                end
                S_SEEK: begin
                    if (!REQ) begin
                        r_sstate <= S_IDLE;
                    end else if (w_frame_err) begin
                        r_sstate <= S_FAIL;
                        r_ack    <= 1'b1;
                        r_err    <= 1'b1;
                    end else if (w_field_end) begin
                        // A hit wins over the index count when the target is sector 0.
                        if (r_asm == r_tgt) begin
                            r_sstate <= S_XFER;
                            r_match  <= 1'b1;
                        end else if (w_asm_zero) begin
                            if (r_idx_seen) begin
                                r_sstate <= S_FAIL;
                                r_ack    <= 1'b1;
                                r_err    <= 1'b1;
                            end else begin
                                r_idx_seen <= 1'b1;
                            end
                        end
                    end
                end
                S_XFER: begin
                    if (!REQ) begin
                        r_sstate <= S_IDLE;
                        r_match  <= 1'b0;
                    end else if (w_frame_err) begin
                        r_sstate <= S_FAIL;
                        r_match  <= 1'b0;
                        r_ack    <= 1'b1;
                        r_err    <= 1'b1;
                    end else if (w_field_end) begin
                        r_sstate <= S_DONE;
                        r_match  <= 1'b0;
                        r_ack    <= 1'b1;
                        r_err    <= 1'b0;
                    end
                end
                S_DONE, S_FAIL: begin
                    if (!REQ) begin
                        r_sstate <= S_IDLE;
                        r_ack    <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                default: begin
                    r_sstate <= S_IDLE;
                    r_match  <= 1'b0;
                    r_ack    <= 1'b0;
                    r_err    <= 1'b0;
                end
            endcase
        end
    end

    assign LOCK       = w_locked;
    assign PH         = r_ph;
    assign SECT       = r_sect;
    assign SECT_VALID = r_sect_valid;
    assign INDEX      = r_index;
    assign MATCH      = r_match;
    assign ACK        = r_ack;
    assign ERR        = r_err;
    assign SYNC_ERR   = r_sync_err;

endmodule

// File: tb/tb_drum_sector_locator.sv
// Randomised bench for drum_sector_locator: a drum track generator drives Z2/Z3 and
// a cycle-level reference model predicts every output after each Z1 edge.
module tb_drum_sector_locator;

    logic       Z1;
    logic       CLR;
    logic       Z2;
    logic       Z3;
    logic       REQ;
    logic [6:0] TGT;
    logic       LOCK;
    logic [5:0] PH;
    logic [6:0] SECT;
    logic       SECT_VALID;
    logic       INDEX;
    logic       MATCH;
    logic       ACK;
    logic       ERR;
    logic       SYNC_ERR;

    drum_sector_locator dut (
        .Z1         (Z1),
        .CLR        (CLR),
        .Z2         (Z2),
        .Z3         (Z3),
        .REQ        (REQ),
        .TGT        (TGT),
        .LOCK       (LOCK),
        .PH         (PH),
        .SECT       (SECT),
        .SECT_VALID (SECT_VALID),
        .INDEX      (INDEX),
        .MATCH      (MATCH),
        .ACK        (ACK),
        .ERR        (ERR),
        .SYNC_ERR   (SYNC_ERR)
    );

    initial Z1 = 1'b0;
    always #5 Z1 = ~Z1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- track generator ----------------
    int g_word;
    int g_bit;
    bit g_skip;
    bit g_force;

    function automatic bit fmt_z2(input int b);
        return ((b >= 31) && (b <= 33)) || ((b >= 38) && (b <= 39));
    endfunction

    function automatic int field_addr(input int w);
        int a;
        a = (w + 1) % 128;
        if (g_skip && (a == 77)) a = 78;
        return a;
    endfunction

    task automatic drive_inputs();
        int a;
        a  = field_addr(g_word);
        Z2 = fmt_z2(g_bit) | g_force;
        if ((g_bit >= 32) && (g_bit <= 38)) Z3 = ((a >> (g_bit - 32)) & 1) != 0;
        else if (g_bit == 39)               Z3 = (a == 0);
        else                                Z3 = 1'($urandom_range(0, 1));
    endtask

    // ---------------- reference model ----------------
    bit m_lock;
    int m_lock_cyc;
    int m_cyc;
    bit m_hist[$];
    bit m_fld[7];
    int m_ph;
    int m_sect;
    bit m_sv;
    bit m_index;
    bit m_syncerr;
    bit m_busy;
    bit m_ack;
    bit m_err;
    int m_match_left;
    int m_idx;
    int m_tgt;

    task automatic model_reset();
        m_lock = 0; m_lock_cyc = 0; m_cyc = 0; m_hist.delete();
        foreach (m_fld[i]) m_fld[i] = 0;
        m_ph = 0; m_sect = 0; m_sv = 0; m_index = 0; m_syncerr = 0;
        m_busy = 0; m_ack = 0; m_err = 0; m_match_left = 0; m_idx = 0; m_tgt = 0;
    endtask

    task automatic model_edge(input bit z2, input bit z3, input bit req, input int tgt);
        bit ev_err;
        bit ev_field;
        bit all0;
        int a;
        int p;
        ev_err = 0; ev_field = 0; a = 0;
        m_cyc++;
        m_index = 0;
        m_syncerr = 0;
        if (!m_lock) begin
            // Lock on a one that follows at least 31 consecutive zeros seen while hunting.
            all0 = (m_hist.size() >= 31);
            foreach (m_hist[i]) if (m_hist[i]) all0 = 0;
            if (z2 && all0) begin
                m_lock = 1; m_lock_cyc = m_cyc; m_ph = 32;
            end else begin
                m_hist.push_back(z2);
                if (m_hist.size() > 31) void'(m_hist.pop_front());
            end
        end else begin
            p = (31 + m_cyc - m_lock_cyc) % 40;
            if ((p >= 32) && (p <= 38)) m_fld[p-32] = z3;
            if (p == 39) for (int i = 0; i < 7; i++) if (m_fld[i]) a += (1 << i);
            if ((z2 != fmt_z2(p)) || ((p == 39) && (z3 != (a == 0)))) begin
                ev_err = 1; m_lock = 0; m_syncerr = 1; m_sv = 0; m_hist.delete();
            end else begin
                m_ph = (p + 1) % 40;
                if (p == 39) begin
                    ev_field = 1; m_sect = a; m_sv = 1; m_index = (a == 0);
                end
            end
        end

        if (m_ack) begin
            if (!req) begin m_ack = 0; m_err = 0; end
        end else if (!m_busy) begin
            if (req) begin m_busy = 1; m_tgt = tgt; m_idx = 0; end
        end else if (!req) begin
            m_busy = 0; m_match_left = 0;
        end else if (ev_err) begin
            m_busy = 0; m_match_left = 0; m_ack = 1; m_err = 1;
        end else if (m_match_left > 0) begin
            m_match_left--;
            if (m_match_left == 0) begin m_busy = 0; m_ack = 1; m_err = 0; end
        end else if (ev_field) begin
            if (a == m_tgt) m_match_left = 40;
            else if (a == 0) begin
                m_idx++;
                if (m_idx >= 2) begin m_busy = 0; m_ack = 1; m_err = 1; end
            end
        end
    endtask

    // ---------------- stepping ----------------
    task automatic step();
        bit z2s, z3s, reqs;
        logic [6:0] tgts;
        logic [19:0] got, exp;
        z2s = Z2; z3s = Z3; reqs = REQ; tgts = TGT;
        @(posedge Z1);
        if (!CLR) model_reset();
        else      model_edge(z2s, z3s, reqs, int'(tgts));
        g_bit++;
        if (g_bit == 40) begin g_bit = 0; g_word = (g_word + 1) % 128; end
        @(negedge Z1);
        got = {LOCK, (m_lock ? PH : 6'd0), SECT, SECT_VALID, INDEX, MATCH, ACK, ERR, SYNC_ERR};
        exp = {m_lock, (m_lock ? 6'(m_ph) : 6'd0), 7'(m_sect), m_sv, m_index,
               (m_match_left > 0), m_ack, m_err, m_syncerr};
        check("outs", 32'(got), 32'(exp));
        drive_inputs();
    endtask

    int  s_match_len;
    int  s_sect_bad;
    bit  s_idx_at_rise;
    bit  s_match_seen;

    task automatic do_search(input int tgt, input int budget);
        bit prev;
        REQ = 1; TGT = 7'(tgt);
        s_match_len = 0; s_sect_bad = 0; s_idx_at_rise = 0; s_match_seen = 0; prev = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (MATCH) begin
                s_match_len++; s_match_seen = 1;
                if (SECT != 7'(tgt)) s_sect_bad++;
                if (!prev) s_idx_at_rise = INDEX;
            end
            prev = MATCH;
            if (ACK) break;
        end
        if (!ACK) check("search_timeout", 32'(ACK), 32'd1);
    endtask

    task automatic wait_lock(input int budget, output int lat);
        lat = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (LOCK) begin lat = i; break; end
        end
    endtask

    task automatic wait_match(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (MATCH) break;
            step();
        end
        if (!MATCH) check("match_timeout", 32'(MATCH), 32'd1);
    endtask

    localparam int SEARCH_BUDGET = 128 * 40 + 200;
    localparam int FAIL_BUDGET   = 3 * 128 * 40 + 200;

    initial begin
        int lat;
        int t;
        CLR = 0; REQ = 0; TGT = '0;
        g_word = 0; g_bit = 0; g_skip = 0; g_force = 0;
        model_reset();
        drive_inputs();
        @(negedge Z1);
        check("reset_outs", 32'({LOCK, PH, SECT, SECT_VALID, INDEX, MATCH, ACK, ERR, SYNC_ERR}), 32'd0);
        repeat (3) step();

        // Clean release aligned to bit 0 of word 0: best-case lock.
        CLR = 1; g_word = 0; g_bit = 0; drive_inputs();
        wait_lock(80, lat);
        check("lock_latency_best", 32'(lat), 32'd32);
        check("ph_after_lock", 32'(PH), 32'd32);
        repeat (8) step();
        check("sect_valid_rise", 32'(SECT_VALID), 32'd1);
        check("sect_first", 32'(SECT), 32'd1);
        repeat (40) step();
        check("sect_second", 32'(SECT), 32'd2);
        repeat (40) step();
        check("sect_third", 32'(SECT), 32'd3);

        do_search(5, SEARCH_BUDGET);
        check("t5_match_len", 32'(s_match_len), 32'd40);
        check("t5_match_sect", 32'(s_sect_bad), 32'd0);
        check("t5_ack", 32'(ACK), 32'd1);
        check("t5_err", 32'(ERR), 32'd0);
        REQ = 0;
        step();
        check("t5_ack_clear", 32'(ACK), 32'd0);

        do_search(0, SEARCH_BUDGET);
        check("t0_index_at_match", 32'(s_idx_at_rise), 32'd1);
        check("t0_match_len", 32'(s_match_len), 32'd40);
        check("t0_err", 32'(ERR), 32'd0);
        REQ = 0; step();

        g_skip = 1;
        do_search(77, FAIL_BUDGET);
        check("t77_ack", 32'(ACK), 32'd1);
        check("t77_err", 32'(ERR), 32'd1);
        check("t77_no_match", 32'(s_match_seen), 32'd0);
        REQ = 0; step();
        g_skip = 0;

        // Corrupt the word-mark at bit 20 of the matched word.
        REQ = 1; TGT = 7'((int'(SECT) + 3) % 128);
        wait_match(SEARCH_BUDGET);
        t = 0;
        while ((g_bit != 20) && (t < 100)) begin step(); t++; end
        g_force = 1; drive_inputs();
        step();
        g_force = 0; drive_inputs();
        check("fault_sync_err", 32'(SYNC_ERR), 32'd1);
        check("fault_match", 32'(MATCH), 32'd0);
        check("fault_lock", 32'(LOCK), 32'd0);
        check("fault_ack", 32'(ACK), 32'd1);
        check("fault_err", 32'(ERR), 32'd1);
        REQ = 0;
        wait_lock(100, lat);
        check("relock_in_71", 32'(lat <= 71), 32'd1);

        // Abandon a search mid-seek, then run a fresh one.
        repeat (45) step();
        REQ = 1; TGT = 7'((int'(SECT) + 64) % 128);
        repeat (20 * 40) step();
        REQ = 0;
        step();
        check("abort_no_ack", 32'(ACK), 32'd0);
        repeat (5) step();
        do_search(3, SEARCH_BUDGET);
        check("t3_ack", 32'(ACK), 32'd1);
        check("t3_err", 32'(ERR), 32'd0);
        check("t3_match_len", 32'(s_match_len), 32'd40);
        REQ = 0; step();

        // Random reset phases and random targets.
        for (int k = 0; k < 3; k++) begin
            CLR = 0; step();
            g_bit = $urandom_range(0, 39); g_word = $urandom_range(0, 127);
            drive_inputs();
            CLR = 1;
            if (k == 0) begin REQ = 1; TGT = 7'($urandom_range(0, 127)); end
            wait_lock(100, lat);
            check("lock_latency_worst", 32'(lat <= 71), 32'd1);
            if (k != 0) begin
                repeat ($urandom_range(0, 60)) step();
                TGT = 7'($urandom_range(0, 127));
                REQ = 1;
            end
            do_search(int'(TGT), SEARCH_BUDGET + 100);
            check("rnd_err", 32'(ERR), 32'd0);
            check("rnd_match_len", 32'(s_match_len), 32'd40);
            REQ = 0; step();
        end

        // Asynchronous reset during the match window.
        REQ = 1; TGT = 7'($urandom_range(0, 127));
        wait_match(SEARCH_BUDGET);
        #2 CLR = 0;
        #1;
        check("async_match", 32'(MATCH), 32'd0);
        check("async_lock", 32'(LOCK), 32'd0);
        REQ = 0;
        step(); step();
        CLR = 1;
        repeat (100) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
